// File: rtl/mem_sched.sv
// rtl/mem_sched.sv - SRAM1/SRAM2/UART access scheduler with registered strobes
// Data accesses run a single FSM; instruction fetch owns SRAM2 whenever no SRAM2 data state is active.
module mem_sched #(
  parameter int unsigned WR_CYCLES      = 2,
  parameter logic [17:0] UART_DATA_ADDR = 18'hBF00,
  parameter logic [17:0] UART_STAT_ADDR = 18'hBF01,
  parameter logic [17:0] RAM2_LIMIT     = 18'h8000
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic [15:0] pc,
  output logic [15:0] if_inst,
  output logic        if_valid,
  input  logic        mem_req,
  input  logic        mem_op,
  input  logic [17:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ack,
  output logic        pause,
  output logic [17:0] sram1_addr,
  output logic [17:0] sram2_addr,
  output logic [15:0] sram1_dout,
  output logic [15:0] sram2_dout,
  output logic        sram1_dout_en,
  output logic        sram2_dout_en,
  input  logic [15:0] sram1_din,
  input  logic [15:0] sram2_din,
  output logic        sram1_en,
  output logic        sram1_oe,
  output logic        sram1_we,
  output logic        sram2_en,
  output logic        sram2_oe,
  output logic        sram2_we,
  input  logic        tsre,
  input  logic        tbre,
  input  logic        data_ready,
  output logic        rdn,
  output logic        wrn
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ADDR, S_RD_SAMPLE, S_WR_SETUP, S_WR_PULSE,
    S_WR_HOLD, S_U_WAIT, S_U_RD, S_U_WR, S_DONE
  } state_e;

  typedef enum logic [1:0] {T_STAT, T_UART, T_RAM2, T_RAM1} tgt_e;

  localparam int CW = $clog2(WR_CYCLES + 2);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  state_e        state_q, state_d;
  tgt_e          tgt_q, tgt_d;
  logic          op_q, op_d;
  logic [17:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic [15:0]   inst_q;
  logic          ivalid_q, fetch_q, fetch_d;

  logic [17:0]   s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [15:0]   s1_dout_q, s1_dout_d, s2_dout_q, s2_dout_d;
  logic          s1_douten_q, s1_douten_d, s2_douten_q, s2_douten_d;
  logic          s1_en_q, s1_en_d, s1_oe_q, s1_oe_d, s1_we_q, s1_we_d;
  logic          s2_en_q, s2_en_d, s2_oe_q, s2_oe_d, s2_we_q, s2_we_d;
  logic          rdn_q, rdn_d, wrn_q, wrn_d;
  logic          rd_st_d, wr_st_d;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The registered ack doubles as the enforced bubble between accesses.
        if (mem_req && !ack_q) begin
          addr_d  = mem_addr;
          op_d    = mem_op;
          wdata_d = mem_wdata;
          cnt_d   = '0;
          if (mem_addr == UART_STAT_ADDR) begin
            tgt_d   = T_STAT;
            rdata_d = {14'b0, data_ready, tsre & tbre};
            state_d = S_DONE;
          end else if (mem_addr == UART_DATA_ADDR) begin
            tgt_d   = T_UART;
            state_d = S_U_WAIT;
          end else begin
            tgt_d   = (mem_addr < RAM2_LIMIT) ? T_RAM2 : T_RAM1;
            state_d = mem_op ? S_WR_SETUP : S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR:   state_d = S_RD_SAMPLE;
      S_RD_SAMPLE: begin
        rdata_d = (tgt_q == T_RAM2) ? sram2_din : sram1_din;
        state_d = S_DONE;
      end
      S_WR_SETUP:  state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_HOLD:   state_d = S_DONE;
      S_U_WAIT: begin
        if (op_q) begin
          if (tsre && tbre) state_d = S_U_WR;
        end else if (data_ready) begin
          state_d = S_U_RD;
        end
      end
      S_U_WR: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_U_RD: begin
        if (cnt_q == CW'(1)) begin
          rdata_d = sram1_din;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so pins change exactly on state boundaries.
  always_comb begin
    rd_st_d     = (state_d == S_RD_ADDR) || (state_d == S_RD_SAMPLE);
    wr_st_d     = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
    s1_addr_d   = s1_addr_q;
    s1_dout_d   = s1_dout_q;
    s1_douten_d = 1'b0;
    s1_en_d     = 1'b1;
    s1_oe_d     = 1'b1;
    s1_we_d     = 1'b1;
    s2_addr_d   = s2_addr_q;
    s2_dout_d   = s2_dout_q;
    s2_douten_d = 1'b0;
    s2_en_d     = 1'b1;
    s2_oe_d     = 1'b1;
    s2_we_d     = 1'b1;
    fetch_d     = 1'b0;
    rdn_d       = (state_d != S_U_RD);
    wrn_d       = (state_d != S_U_WR);

    if ((rd_st_d || wr_st_d) && tgt_d == T_RAM1) begin
      s1_addr_d = addr_d;
      s1_en_d   = 1'b0;
      s1_oe_d   = !rd_st_d;
      if (wr_st_d) begin
        s1_dout_d   = wdata_d;
        s1_douten_d = 1'b1;
        s1_we_d     = (state_d != S_WR_PULSE);
      end
    end

    // UART write data is driven from U_WAIT through DONE to give setup and hold around WRN.
    if (tgt_d == T_UART && op_d &&
        (state_d == S_U_WAIT || state_d == S_U_WR || state_d == S_DONE)) begin
      s1_dout_d   = wdata_d;
      s1_douten_d = 1'b1;
    end

    if ((rd_st_d || wr_st_d) && tgt_d == T_RAM2) begin
      s2_addr_d = addr_d;
      s2_en_d   = 1'b0;
      s2_oe_d   = !rd_st_d;
      if (wr_st_d) begin
        s2_dout_d   = wdata_d;
        s2_douten_d = 1'b1;
        s2_we_d     = (state_d != S_WR_PULSE);
      end
    end else begin
      s2_addr_d = {2'b00, pc};
      s2_en_d   = 1'b0;
      s2_oe_d   = 1'b0;
      fetch_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tgt_q       <= T_STAT;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      inst_q      <= '0;
      ivalid_q    <= 1'b0;
      fetch_q     <= 1'b0;
      s1_addr_q   <= '0;
      s1_dout_q   <= '0;
      s1_douten_q <= 1'b0;
      s1_en_q     <= 1'b1;
      s1_oe_q     <= 1'b1;
      s1_we_q     <= 1'b1;
      s2_addr_q   <= '0;
      s2_dout_q   <= '0;
      s2_douten_q <= 1'b0;
      s2_en_q     <= 1'b1;
      s2_oe_q     <= 1'b1;
      s2_we_q     <= 1'b1;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      fetch_q     <= fetch_d;
      ivalid_q    <= fetch_q;
      if (fetch_q) inst_q <= sram2_din;
      s1_addr_q   <= s1_addr_d;
      s1_dout_q   <= s1_dout_d;
      s1_douten_q <= s1_douten_d;
      s1_en_q     <= s1_en_d;
      s1_oe_q     <= s1_oe_d;
      s1_we_q     <= s1_we_d;
      s2_addr_q   <= s2_addr_d;
      s2_dout_q   <= s2_dout_d;
      s2_douten_q <= s2_douten_d;
      s2_en_q     <= s2_en_d;
      s2_oe_q     <= s2_oe_d;
      s2_we_q     <= s2_we_d;
      rdn_q       <= rdn_d;
      wrn_q       <= wrn_d;
    end
  end

  assign if_inst       = inst_q;
  assign if_valid      = ivalid_q;
  assign mem_rdata     = rdata_q;
  assign mem_ack       = ack_q;
  assign pause         = mem_req & ~ack_q;
  assign sram1_addr    = s1_addr_q;
  assign sram2_addr    = s2_addr_q;
  assign sram1_dout    = s1_dout_q;
  assign sram2_dout    = s2_dout_q;
  assign sram1_dout_en = s1_douten_q;
  assign sram2_dout_en = s2_douten_q;
  assign sram1_en      = s1_en_q;
  assign sram1_oe      = s1_oe_q;
  assign sram1_we      = s1_we_q;
  assign sram2_en      = s2_en_q;
  assign sram2_oe      = s2_oe_q;
  assign sram2_we      = s2_we_q;
  assign rdn           = rdn_q;
  assign wrn           = wrn_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb/tb_mem_sched.sv - randomized self-checking bench for mem_sched
// Pin-level SRAM/UART models plus an address-keyed reference memory and latency rules.
module tb_mem_sched;

  localparam int WR = 2;

  logic        clk_50MHz = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] if_inst;
  logic        if_valid;
  logic        mem_req, mem_op;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack, pause;
  logic [17:0] sram1_addr, sram2_addr;
  logic [15:0] sram1_dout, sram2_dout, sram1_din, sram2_din;
  logic        sram1_dout_en, sram2_dout_en;
  logic        sram1_en, sram1_oe, sram1_we, sram2_en, sram2_oe, sram2_we;
  logic        tsre, tbre, data_ready, rdn, wrn;

  int n_checks = 0;
  int n_errors = 0;

  mem_sched #(.WR_CYCLES(WR)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .pc(pc), .if_inst(if_inst), .if_valid(if_valid),
    .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pause(pause),
    .sram1_addr(sram1_addr), .sram2_addr(sram2_addr), .sram1_dout(sram1_dout),
    .sram2_dout(sram2_dout), .sram1_dout_en(sram1_dout_en), .sram2_dout_en(sram2_dout_en),
    .sram1_din(sram1_din), .sram2_din(sram2_din),
    .sram1_en(sram1_en), .sram1_oe(sram1_oe), .sram1_we(sram1_we),
    .sram2_en(sram2_en), .sram2_oe(sram2_oe), .sram2_we(sram2_we),
    .tsre(tsre), .tbre(tbre), .data_ready(data_ready), .rdn(rdn), .wrn(wrn)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [17:0] a, input bit r2);
    return a[15:0] ^ (r2 ? 16'h5A5A : 16'hC3C3);
  endfunction

  // Pin-level SRAM and UART models.
  logic [15:0] mem1 [0:262143];
  logic [15:0] mem2 [0:262143];
  bit          wr1  [0:262143];
  bit          wr2  [0:262143];
  logic [15:0] uart_rx, uart_tx_last;

  assign sram2_din = (!sram2_en && !sram2_oe) ?
                     (wr2[sram2_addr] ? mem2[sram2_addr] : init_word(sram2_addr, 1'b1)) : 16'hDEAD;
  assign sram1_din = !rdn ? uart_rx :
                     (!sram1_en && !sram1_oe) ?
                     (wr1[sram1_addr] ? mem1[sram1_addr] : init_word(sram1_addr, 1'b0)) : 16'hDEAD;

  always @(posedge clk_50MHz) begin
    if (!sram2_en && !sram2_we && sram2_dout_en) begin
      mem2[sram2_addr] <= sram2_dout;
      wr2[sram2_addr]  <= 1'b1;
    end
    if (!sram1_en && !sram1_we && sram1_dout_en) begin
      mem1[sram1_addr] <= sram1_dout;
      wr1[sram1_addr]  <= 1'b1;
    end
    if (!wrn) uart_tx_last <= sram1_dout;
  end

  // Reference memory: what each address should hold after completed writes.
  logic [15:0] ref1 [int];
  logic [15:0] ref2 [int];

  function automatic logic [15:0] ref_rd(input bit r2, input logic [17:0] a);
    if (r2) return ref2.exists(int'(a)) ? ref2[int'(a)] : init_word(a, 1'b1);
    return ref1.exists(int'(a)) ? ref1[int'(a)] : init_word(a, 1'b0);
  endfunction

  // Fetch monitor: if_inst holds the word at the pc latched two edges earlier.
  logic [15:0] pc_e1, pc_e2;
  logic        ack_prev = 1'b0;
  int          dbl_ack = 0;
  always @(posedge clk_50MHz) begin
    pc_e1 <= pc;
    pc_e2 <= pc_e1;
  end
  always @(negedge clk_50MHz) begin
    if (if_valid) check("fetch_word", if_inst, ref_rd(1'b1, {2'b00, pc_e2}));
    if (mem_ack && ack_prev) dbl_ack <= dbl_ack + 1;
    ack_prev <= mem_ack;
  end

  initial begin
    pc = 16'h1000;
    forever begin
      @(posedge clk_50MHz);
      #1;
      pc = 16'h1000 + 16'($urandom_range(0, 255));
    end
  end

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  // One access. b2b: mem_req was left high through the previous ack cycle.
  task automatic run_txn(input logic op, input logic [17:0] a, input logic [15:0] wd,
                         input int udly, input logic [2:0] st, input bit b2b);
    bit is_stat, is_uart, is_r2, is_r1, got;
    int exp_lat, extra, k, we1_lo, we2_lo, wrn_lo, rdn_lo, ivl_lo, s1en_lo, clash, pause_lo;
    logic [15:0] exp_rd;
    is_stat = (a == 18'hBF01);
    is_uart = (a == 18'hBF00);
    is_r2   = !is_stat && !is_uart && (a < 18'h8000);
    is_r1   = !is_stat && !is_uart && !is_r2;
    if (is_stat)      exp_lat = 1;
    else if (is_uart) exp_lat = op ? 2 + WR + udly : 4 + udly;
    else              exp_lat = op ? 3 + WR : 3;
    extra = b2b ? 1 : 0;

    data_ready = 1'b0; tsre = 1'b1; tbre = 1'b1;
    if (is_stat) {data_ready, tsre, tbre} = st;
    if (is_uart) begin
      uart_rx = wd;
      if (op) tbre = (udly == 0);
      else    data_ready = (udly == 0);
    end
    exp_rd = is_stat ? {14'b0, st[2], st[1] & st[0]} : is_uart ? wd : ref_rd(is_r2, a);

    mem_req = 1'b1; mem_op = op; mem_addr = a; mem_wdata = wd;
    got = 0; k = 0;
    we1_lo = 0; we2_lo = 0; wrn_lo = 0; rdn_lo = 0; ivl_lo = 0; s1en_lo = 0; clash = 0; pause_lo = 0;
    while (!got && k < 200) begin
      tick();
      k++;
      if (is_uart && udly > 0 && k == udly + 1 + extra) begin
        if (op) tbre = 1'b1;
        else    data_ready = 1'b1;
      end
      if (mem_ack) got = 1;
      else if (!pause) pause_lo++;
      we1_lo  += int'(!sram1_we);
      we2_lo  += int'(!sram2_we);
      wrn_lo  += int'(!wrn);
      rdn_lo  += int'(!rdn);
      ivl_lo  += int'(!if_valid);
      s1en_lo += int'(!sram1_en);
      clash   += int'(!sram1_we && !sram1_oe) + int'(!sram2_we && !sram2_oe);
    end
    check("ack_seen", 32'(got), 1);
    check("latency", k - 1 - extra, exp_lat);
    check("pause_pre_ack", pause_lo, 0);
    check("pause_at_ack", pause, 0);
    check("we_oe_clash", clash, 0);
    check("sram1_we_low", we1_lo, (is_r1 && op) ? WR : 0);
    check("sram2_we_low", we2_lo, (is_r2 && op) ? WR : 0);
    check("wrn_low", wrn_lo, (is_uart && op) ? WR : 0);
    check("rdn_low", rdn_lo, (is_uart && !op) ? 2 : 0);
    check("if_valid_gap", ivl_lo, is_r2 ? (op ? WR + 2 : 2) : 0);
    if (is_uart) check("uart_sram1_en", s1en_lo, 0);
    if (!op || is_stat) check("rdata", mem_rdata, exp_rd);
    if (is_uart && op) begin
      tick();
      check("uart_tx", uart_tx_last, wd);
      mem_req = 1'b0;
    end else if (op && is_r2) begin
      ref2[int'(a)] = wd;
    end else if (op && is_r1) begin
      ref1[int'(a)] = wd;
    end
  endtask

  task automatic idle_then(input logic op, input logic [17:0] a, input logic [15:0] wd,
                           input int udly, input logic [2:0] st);
    mem_req = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    run_txn(op, a, wd, udly, st, 1'b0);
  endtask

  initial begin
    logic [17:0] a;
    int kind;
    bit b2b;
    rst = 1'b0; mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h0040; mem_wdata = 16'hFFFF;
    tsre = 1'b1; tbre = 1'b1; data_ready = 1'b0; uart_rx = 16'h0;
    repeat (3) tick();
    check("rst_strobes", {sram1_en, sram1_oe, sram1_we, sram2_en, sram2_oe, sram2_we, rdn, wrn}, 8'hFF);
    check("rst_dout_en", {sram1_dout_en, sram2_dout_en}, 2'b00);
    check("rst_ack", mem_ack, 0);
    check("rst_pause", pause, 1);
    check("rst_if", {if_valid, if_inst}, 17'h0);
    check("rst_rdata", mem_rdata, 16'h0);
    check("rst_addr", {sram1_addr, sram2_addr}, 36'h0);
    check("rst_dout", {sram1_dout, sram2_dout}, 32'h0);
    mem_req = 1'b0;
    rst = 1'b1;
    repeat (4) tick();

    idle_then(1'b1, 18'h00040, 16'hA5C3, 0, 3'b000);
    idle_then(1'b0, 18'h00040, 16'h0000, 0, 3'b000);
    idle_then(1'b1, 18'h09000, 16'h1234, 0, 3'b000);
    idle_then(1'b0, 18'h09000, 16'h0000, 0, 3'b000);
    idle_then(1'b1, 18'h07FFF, 16'h7777, 0, 3'b000);
    idle_then(1'b1, 18'h08000, 16'h8888, 0, 3'b000);
    idle_then(1'b1, 18'h3BF00, 16'h3B00, 0, 3'b000);
    idle_then(1'b0, 18'h07FFF, 16'h0000, 0, 3'b000);
    idle_then(1'b0, 18'h08000, 16'h0000, 0, 3'b000);
    idle_then(1'b0, 18'h3BF00, 16'h0000, 0, 3'b000);
    idle_then(1'b1, 18'h0BF00, 16'h00AB, 5, 3'b000);
    idle_then(1'b0, 18'h0BF00, 16'h0041, 4, 3'b000);
    idle_then(1'b0, 18'h0BF01, 16'h0000, 0, 3'b111);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0:       a = 18'h0BF01;
        1, 2:    a = 18'h0BF00;
        3, 4:    a = 18'($urandom_range(0, 255));
        default: a = 18'h09000 + 18'($urandom_range(0, 255));
      endcase
      b2b = ($urandom_range(0, 1) == 1) && mem_req;
      if (b2b)
        run_txn(kind inside {2, 4, 6}, a, 16'($urandom), $urandom_range(0, 6), 3'($urandom), 1'b1);
      else
        idle_then(kind inside {2, 4, 6}, a, 16'($urandom), $urandom_range(0, 6), 3'($urandom));
    end

    // Reset in the middle of a write pulse must release WE on the very next edge.
    mem_req = 1'b0;
    repeat (2) tick();
    mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h07FF0; mem_wdata = 16'h5555;
    repeat (3) tick();
    check("midwr_we_low", sram2_we, 0);
    rst = 1'b0;
    tick();
    check("midwr_we_rel", sram2_we, 1);
    check("midwr_dout_en", sram2_dout_en, 0);
    check("midwr_ack", mem_ack, 0);
    mem_req = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    idle_then(1'b0, 18'h00040, 16'h0000, 0, 3'b000);

    mem_req = 1'b0;
    repeat (3) tick();
    check("double_ack", dbl_ack, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
